da2_sample_pacer: RTL and testbench

//  Upstream feeder for the DA2 serial interface: buffers 12-bit samples (+ 2-bit channel mode) in a small FIFO
//  and releases one sample per programmable sample period by driving value/chmode/update into the DA2 interface.

---
 rtl/da2_pkg.sv | 15 +
 rtl/da2_sample_fifo.sv | 53 +++++
 rtl/da2_sample_pacer.sv | 99 +++++++++
 tb/tb_da2_sample_pacer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/da2_pkg.sv
// da2_pkg: shared types and constants for the DA2 sample feeder.
package da2_pkg;
    localparam int SAMPLE_W = 12;
    localparam logic [1:0] CH_ON   = 2'b00;
    localparam logic [1:0] CH_1K   = 2'b01;
    localparam logic [1:0] CH_100K = 2'b10;
    localparam logic [1:0] CH_HIZ  = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, ACK, XFER} state_t;

    typedef struct packed {
        logic [1:0]          chmode;
        logic [SAMPLE_W-1:0] value;
    } frame_t;
endpackage

// File: rtl/da2_sample_fifo.sv
// da2_sample_fifo: synchronous frame FIFO with exact occupancy count.
module da2_sample_fifo
    import da2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  frame_t                 din,
    input  logic                   pop,
    output frame_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    frame_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] lvl_q, lvl_d;
    logic do_push, do_pop;

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        lvl_d   = lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign full  = lvl_q == (AW+1)'(DEPTH);
    assign empty = lvl_q == '0;
    assign level = lvl_q;
endmodule

// File: rtl/da2_sample_pacer.sv
// da2_sample_pacer: releases one buffered sample per programmable period to the DA2 interface,
// holding value/chmode stable through the serial transfer.
module da2_sample_pacer
    import da2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [DIV_W-1:0]       period,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [SAMPLE_W-1:0]    s_value,
    input  logic [1:0]             s_chmode,
    output logic [SAMPLE_W-1:0]    value,
    output logic [1:0]             chmode,
    output logic                   update,
    input  logic                   SYNC,
    input  logic                   SCLK_en,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   underrun,
    output logic                   late
);
    state_t state_q, state_d;
    frame_t frame_q, frame_d, head;
    logic [DIV_W-1:0] cnt_q, cnt_d, per_q, per_d, per_eff;
    logic update_q, update_d, underrun_q, underrun_d, late_q, late_d;
    logic tick, launch, full, empty;

    da2_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .din   ({s_chmode, s_value}),
        .pop   (launch),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // The live period is only taken while the counter sits at zero.
    always_comb begin
        per_eff = (cnt_q == '0) ? period : per_q;
        tick    = enable && (per_eff <= DIV_W'(1) || cnt_q == per_eff - DIV_W'(1));
        per_d   = per_eff;
        cnt_d   = (!enable || tick) ? '0 : cnt_q + DIV_W'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (tick && !empty) ? REQ : IDLE;
            REQ:     state_d = SYNC ? ACK : REQ;
            ACK:     state_d = SCLK_en ? XFER : ACK;
            XFER:    state_d = SCLK_en ? XFER : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        launch     = state_q == IDLE && tick && !empty;
        frame_d    = launch ? head : frame_q;
        update_d   = launch ? 1'b1 : (state_q == REQ && SYNC) ? 1'b0 : update_q;
        underrun_d = tick && state_q == IDLE && empty;
        late_d     = tick && state_q != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            cnt_q      <= '0;
            per_q      <= '0;
            update_q   <= 1'b0;
            underrun_q <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            update_q   <= update_d;
            underrun_q <= underrun_d;
            late_q     <= late_d;
        end
    end

    assign s_ready  = ~full;
    assign value    = frame_q.value;
    assign chmode   = frame_q.chmode;
    assign update   = update_q;
    assign busy     = state_q != IDLE;
    assign underrun = underrun_q;
    assign late     = late_q;
endmodule

// File: tb/tb_da2_sample_pacer.sv
// tb_da2_sample_pacer: pacer driven against a behavioural DA2 responder and a queue-based reference model.
module tb_da2_sample_pacer;
    import da2_pkg::*;
    localparam int DEPTH = 8;
    localparam int DIV_W = 16;
    localparam int XL = 16;

    logic clk = 1'b0;
    logic rst, enable, s_valid, s_ready, update, SYNC, SCLK_en, busy, underrun, late;
    logic [DIV_W-1:0] period;
    logic [11:0] s_value, value;
    logic [1:0] s_chmode, chmode;
    logic [$clog2(DEPTH):0] level;

    always #5 clk = ~clk;

    da2_sample_pacer #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period),
        .s_valid(s_valid), .s_ready(s_ready), .s_value(s_value), .s_chmode(s_chmode),
        .value(value), .chmode(chmode), .update(update), .SYNC(SYNC), .SCLK_en(SCLK_en),
        .busy(busy), .level(level), .underrun(underrun), .late(late)
    );

    int n_tests = 0, n_fail = 0;

    // Reference model: FIFO as a queue, transfer tracked as "in flight" milestones.
    logic [13:0] mq[$];
    logic [13:0] m_frame;
    int m_cnt, m_plen;
    bit m_busy, m_ss, m_sc, m_update, m_under, m_late;

    int rp, rw;
    logic [15:0] sdata;
    int cyc, rise_cnt, ur_cnt, lt_cnt, first_ur;
    int rise_t[$];
    logic [13:0] launched[$];
    bit upd_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        int plen;
        bit tick;
        int n_pre;
        if (rst) begin
            mq.delete();
            m_cnt = 0; m_plen = 0; m_busy = 0; m_ss = 0; m_sc = 0;
            m_update = 0; m_under = 0; m_late = 0; m_frame = '0;
            return;
        end
        plen = (m_cnt == 0) ? int'(period) : m_plen;
        m_plen = plen;
        tick = enable && (plen <= 1 || m_cnt == plen - 1);
        m_cnt = (!enable || tick) ? 0 : m_cnt + 1;
        n_pre = mq.size();
        m_under = tick && !m_busy && n_pre == 0;
        m_late = tick && m_busy;
        if (m_busy) begin
            if (!m_ss) begin
                if (SYNC) begin m_ss = 1; m_update = 0; end
            end else if (!m_sc) begin
                if (SCLK_en) m_sc = 1;
            end else if (!SCLK_en) m_busy = 0;
        end else if (tick && n_pre > 0) begin
            m_frame = mq.pop_front();
            m_update = 1; m_busy = 1; m_ss = 0; m_sc = 0;
        end
        if (s_valid && n_pre < DEPTH) mq.push_back({s_chmode, s_value});
    endtask

    task automatic responder();
        if (rst) begin
            rp = 0; SYNC = 0; SCLK_en = 0;
            return;
        end
        case (rp)
            0: begin
                SYNC = 0; SCLK_en = 0;
                if (update === 1'b1) begin rp = 1; rw = $urandom_range(0, 2); end
            end
            1: if (rw == 0) begin SYNC = 1; sdata = {2'b00, chmode, value}; rp = 2; end else rw--;
            2: begin SYNC = 0; SCLK_en = 1; rw = XL - 1; rp = 3; end
            default: if (rw == 0) begin SCLK_en = 0; rp = 0; end else rw--;
        endcase
    endtask

    // One clock: respond, advance model, cross the edge, compare at the following negedge.
    task automatic step();
        responder();
        model_edge();
        @(negedge clk);
        cyc++;
        chk("value", value, m_frame[11:0]);
        chk("chmode", chmode, m_frame[13:12]);
        chk("update", update, m_update);
        chk("busy", busy, m_busy);
        chk("level", level, mq.size());
        chk("s_ready", s_ready, mq.size() < DEPTH);
        chk("underrun", underrun, m_under);
        chk("late", late, m_late);
        if (update === 1'b1 && !upd_prev) begin
            rise_cnt++; rise_t.push_back(cyc); launched.push_back({chmode, value});
        end
        upd_prev = (update === 1'b1);
        if (underrun === 1'b1) begin
            if (ur_cnt == 0) first_ur = cyc;
            ur_cnt++;
        end
        if (late === 1'b1) lt_cnt++;
    endtask

    task automatic clear_stats();
        cyc = 0; rise_cnt = 0; ur_cnt = 0; lt_cnt = 0; first_ur = -1;
        rise_t.delete(); launched.delete();
    endtask

    task automatic do_reset();
        rst = 1; enable = 0; s_valid = 0;
        step(); step();
        rst = 0;
    endtask

    task automatic push(input logic [11:0] v, input logic [1:0] ch);
        s_valid = 1; s_value = v; s_chmode = ch;
        step();
        s_valid = 0;
    endtask

    typedef struct {
        logic        valid;
        logic [11:0] val;
        int          exp_level;
        logic        exp_ready;
    } vec_t;
    vec_t tbl[11];

    initial begin
        bit stable;
        int t;
        rst = 1; enable = 0; period = '0; s_valid = 0; s_value = '0; s_chmode = '0;
        SYNC = 0; SCLK_en = 0; rp = 0; rw = 0; sdata = '0; upd_prev = 0;
        clear_stats();

        for (int i = 0; i < 10; i++) begin
            tbl[i].valid = 1;
            tbl[i].val = 12'h200 + 12'(i);
            tbl[i].exp_level = (i + 1 < DEPTH) ? i + 1 : DEPTH;
            tbl[i].exp_ready = (i + 1 < DEPTH);
        end
        tbl[10] = '{1'b0, 12'h000, DEPTH, 1'b0};

        do_reset();
        chk("rst_value", value, 0);
        chk("rst_chmode", chmode, 0);
        chk("rst_update", update, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_underrun", underrun, 0);
        chk("rst_late", late, 0);

        // Two queued samples, period 100.
        do_reset();
        period = 100;
        push(12'h123, CH_ON);
        push(12'hABC, CH_ON);
        clear_stats();
        enable = 1;
        for (int k = 0; k < 260; k++) step();
        chk("t1_rises", rise_cnt, 2);
        chk("t1_rise0_cyc", (rise_t.size() > 0) ? rise_t[0] : -1, 100);
        chk("t1_rise1_cyc", (rise_t.size() > 1) ? rise_t[1] : -1, 200);
        chk("t1_val0", (launched.size() > 0) ? launched[0] : 14'h3FFF, {CH_ON, 12'h123});
        chk("t1_val1", (launched.size() > 1) ? launched[1] : 14'h3FFF, {CH_ON, 12'hABC});

        // Empty FIFO: underrun every period, nothing launched.
        do_reset();
        period = 100;
        clear_stats();
        enable = 1;
        for (int k = 0; k < 300; k++) step();
        chk("t2_underruns", ur_cnt, 3);
        chk("t2_first_ur", first_ur, 100);
        chk("t2_no_update", rise_cnt, 0);
        chk("t2_value", value, 0);

        // Period shorter than the transfer: late ticks, no data lost.
        do_reset();
        period = 4;
        for (int i = 0; i < 4; i++) push(12'h100 + 12'(i), 2'(i));
        clear_stats();
        enable = 1;
        for (int k = 0; k < 200; k++) step();
        chk("t3_late_seen", lt_cnt > 0, 1);
        chk("t3_launches", launched.size(), 4);
        for (int i = 0; i < 4 && i < launched.size(); i++)
            chk("t3_order", launched[i], {2'(i), 12'h100 + 12'(i)});
        chk("t3_level", level, 0);

        // Fill past full with pacing disabled.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            s_valid = tbl[i].valid; s_value = tbl[i].val; s_chmode = CH_1K;
            step();
            chk("t4_level", level, tbl[i].exp_level);
            chk("t4_s_ready", s_ready, tbl[i].exp_ready);
        end
        s_valid = 0;

        // Reset in the middle of a serial transfer.
        do_reset();
        push(12'h555, CH_100K);
        push(12'h666, CH_100K);
        period = 1;
        enable = 1;
        t = 0;
        while (!(rp == 3 && rw < 10) && t < 60) begin step(); t++; end
        chk("t5_in_xfer", (rp == 3) && busy, 1);
        rst = 1;
        step();
        chk("t5_update", update, 0);
        chk("t5_busy", busy, 0);
        chk("t5_level", level, 0);
        chk("t5_value", value, 0);
        chk("t5_chmode", chmode, 0);
        rst = 0;

        // Hi-Z sample at period 1: held through transfer, frame bits on the wire.
        do_reset();
        sdata = '0;
        period = 1;
        push(12'h7FF, CH_HIZ);
        enable = 1;
        step();
        chk("t6_update_next", update, 1);
        stable = 1;
        t = 0;
        while (busy === 1'b1 && t < 60) begin
            if (value !== 12'h7FF || chmode !== CH_HIZ) stable = 0;
            step(); t++;
        end
        chk("t6_done", busy, 0);
        chk("t6_stable", stable, 1);
        chk("t6_sdata", sdata, 16'h37FF);

        // Randomised traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k % 64 == 0) begin
                case ($urandom_range(0, 7))
                    0: period = 0;
                    1: period = 1;
                    2: period = 2;
                    3: period = 3;
                    4: period = 5;
                    5: period = 8;
                    6: period = 25;
                    default: period = 40;
                endcase
            end
            if ($urandom_range(0, 63) == 0) period = 16'($urandom_range(0, 30));
            enable = ($urandom_range(0, 9) != 0);
            s_valid = ($urandom_range(0, 9) < 4);
            s_value = 12'($urandom);
            s_chmode = 2'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 0; s_valid = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
